// File: rtl/sram_rw_port_ctrl.sv
// Single-port SRAM front end: write/read arbitration, read credit, 2-entry response FIFO.
// Optional post-reset array clear sweep is compiled in with `define SRAM_CTRL_INIT_EN.
module sram_rw_port_ctrl #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 20,
  parameter int MASK_W = 10
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [MASK_W-1:0] w_mask,
  input  logic              r_req_valid,
  output logic              r_req_ready,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              r_resp_valid,
  input  logic              r_resp_ready,
  output logic [DATA_W-1:0] r_resp_data,
  output logic              init_done,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic [MASK_W-1:0] sram_wmask,
  input  logic [DATA_W-1:0] sram_rdata
);

  logic              run_s;
  logic              sweep_s;
  logic [ADDR_W-1:0] sweep_addr_s;

`ifdef SRAM_CTRL_INIT_EN
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ADDR_W-1:0] cnt_r;
  logic [ADDR_W-1:0] cnt_nxt_s;

  // State and sweep address registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_INIT;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Sweep sequencing: one clear write per cycle, leave INIT after the last address
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_INIT: begin
        cnt_nxt_s = cnt_r + ADDR_W'(1);
        if (cnt_r == LAST_ADDR) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_RUN: begin
        cnt_nxt_s   = cnt_r;
        state_nxt_s = ST_RUN;
      end
      default: begin
        cnt_nxt_s   = '0;
        state_nxt_s = ST_INIT;
      end
    endcase
  end

  // The macro must stay quiet while reset is held even though INIT is the reset state
  assign run_s        = (state_r == ST_RUN);
  assign sweep_s      = (state_r == ST_INIT) && reset_n;
  assign sweep_addr_s = cnt_r;
  assign init_done    = run_s;
`else
  assign run_s        = reset_n;
  assign sweep_s      = 1'b0;
  assign sweep_addr_s = '0;
  assign init_done    = 1'b1;
`endif

  logic              s1_valid_r;
  logic [1:0]        fifo_cnt_r;
  logic              rd_ptr_r;
  logic              wr_ptr_r;
  logic [DATA_W-1:0] fifo_mem_r [2];
  logic [1:0]        starve_r;
  logic [1:0]        starve_nxt_s;
  logic [2:0]        outstanding_s;
  logic              pop_s;
  logic              push_s;
  logic              credit_s;
  logic              read_forced_s;
  logic              w_fire_s;
  logic              r_fire_s;

  // A pop this cycle frees a slot for a read issued in the same cycle
  assign pop_s         = r_resp_valid && r_resp_ready;
  assign push_s        = s1_valid_r;
  assign outstanding_s = {2'b00, s1_valid_r} + {1'b0, fifo_cnt_r};
  assign credit_s      = (outstanding_s - {2'b00, pop_s}) < 3'd2;
  assign read_forced_s = run_s && (starve_r == 2'd3) && r_req_valid;

  assign w_ready     = run_s && !read_forced_s;
  assign r_req_ready = run_s && credit_s && (!w_valid || read_forced_s);
  assign w_fire_s    = w_valid && w_ready;
  assign r_fire_s    = r_req_valid && r_req_ready;

  assign r_resp_valid = (fifo_cnt_r != 2'd0);
  assign r_resp_data  = fifo_mem_r[rd_ptr_r];

  // Starvation counter: counts reads that had credit but lost to a write
  always_comb begin
    starve_nxt_s = starve_r;
    if (!r_req_valid || r_fire_s) begin
      starve_nxt_s = 2'd0;
    end else if (w_fire_s && credit_s && (starve_r != 2'd3)) begin
      starve_nxt_s = starve_r + 2'd1;
    end else begin
      starve_nxt_s = starve_r;
    end
  end

  // SRAM command mux: sweep, then winning write, then winning read
  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_wmask = '0;
    if (sweep_s) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = sweep_addr_s;
      sram_wdata = '0;
      sram_wmask = '1;
    end else if (w_fire_s) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = w_addr;
      sram_wdata = w_data;
      sram_wmask = w_mask;
    end else if (r_fire_s) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b0;
      sram_addr  = r_addr;
    end else begin
      sram_en    = 1'b0;
      sram_wmode = 1'b0;
    end
  end

  // Read pipeline stage, starvation counter and response FIFO
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_r    <= 1'b0;
      starve_r      <= 2'd0;
      fifo_cnt_r    <= 2'd0;
      rd_ptr_r      <= 1'b0;
      wr_ptr_r      <= 1'b0;
      fifo_mem_r[0] <= '0;
      fifo_mem_r[1] <= '0;
    end else begin
      s1_valid_r <= r_fire_s;
      starve_r   <= starve_nxt_s;
      fifo_cnt_r <= fifo_cnt_r + {1'b0, push_s} - {1'b0, pop_s};
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= sram_rdata;
        wr_ptr_r             <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
    end
  end

endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
// Self-checking bench for sram_rw_port_ctrl with a behavioural SRAM and a memory/queue reference model.
module tb_sram_rw_port_ctrl;
  localparam int AW = 8;
  localparam int DW = 20;
  localparam int MW = 10;
  localparam int DEPTH = 256;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          w_valid, w_ready;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic [MW-1:0] w_mask;
  logic          r_req_valid, r_req_ready;
  logic [AW-1:0] r_addr;
  logic          r_resp_valid, r_resp_ready;
  logic [DW-1:0] r_resp_data;
  logic          init_done;
  logic          sram_en, sram_wmode;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [MW-1:0] sram_wmask;
  logic [DW-1:0] sram_rdata;

  logic [DW-1:0] sram_mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  sram_rw_port_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_data(w_data), .w_mask(w_mask),
    .r_req_valid(r_req_valid), .r_req_ready(r_req_ready), .r_addr(r_addr),
    .r_resp_valid(r_resp_valid), .r_resp_ready(r_resp_ready), .r_resp_data(r_resp_data),
    .init_done(init_done), .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_wmask(sram_wmask), .sram_rdata(sram_rdata)
  );

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [MW-1:0] m);
    logic [DW-1:0] em;
    for (int i = 0; i < MW; i++) em[2*i +: 2] = {2{m[i]}};
    return (old & ~em) | (d & em);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural SRAM macro: masked write, one-cycle registered read
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) sram_mem[sram_addr] <= merge(sram_mem[sram_addr], sram_wdata, sram_wmask);
      else sram_rdata <= sram_mem[sram_addr];
    end
  end

  // Reference model: expected memory image plus in-order queue of expected responses
  always @(negedge clock) begin
    if (reset_n) begin
      if (r_resp_valid && r_resp_ready) begin
        check("resp_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          check("resp_data", 32'(r_resp_data), 32'(exp_q[0]));
          void'(exp_q.pop_front());
        end
      end
      if (w_valid && w_ready) ref_mem[w_addr] = merge(ref_mem[w_addr], w_data, w_mask);
      if (r_req_valid && r_req_ready) begin
        check("read_credit", {31'd0, exp_q.size() < 2}, 32'd1);
        exp_q.push_back(ref_mem[r_addr]);
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
    logic done = 1'b0;
    w_valid = 1'b1; w_addr = a; w_data = d; w_mask = m;
    for (int k = 0; k < 50 && !done; k++) begin
      #1;
      done = w_ready;
      cyc();
    end
    check("write_accept", {31'd0, done}, 32'd1);
    w_valid = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    logic done = 1'b0;
    r_req_valid = 1'b1; r_addr = a;
    for (int k = 0; k < 50 && !done; k++) begin
      #1;
      done = r_req_ready;
      cyc();
    end
    check("read_accept", {31'd0, done}, 32'd1);
    r_req_valid = 1'b0;
  endtask

  task automatic read_expect(input logic [AW-1:0] a, input logic [DW-1:0] e, input string tag);
    r_resp_ready = 1'b1;
    do_read(a);
    check({tag, "_t1_valid"}, {31'd0, r_resp_valid}, 32'd0);
    cyc();
    check({tag, "_t2_valid"}, {31'd0, r_resp_valid}, 32'd1);
    check({tag, "_data"}, 32'(r_resp_data), 32'(e));
  endtask

  task automatic drain();
    int k = 0;
    r_resp_ready = 1'b1;
    while (exp_q.size() != 0 && k < 30) begin
      cyc();
      k++;
    end
    check("drain", exp_q.size(), 32'd0);
  endtask

  initial begin
    logic exp_init_rst;
    int acc;
    int sweep_bad;
`ifdef SRAM_CTRL_INIT_EN
    exp_init_rst = 1'b0;
`else
    exp_init_rst = 1'b1;
`endif
    reset_n = 1'b0; w_valid = 1'b0; w_addr = '0; w_data = '0; w_mask = '0;
    r_req_valid = 1'b0; r_addr = '0; r_resp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    #12;
    check("rst_init_done", {31'd0, init_done}, {31'd0, exp_init_rst});
    check("rst_w_ready", {31'd0, w_ready}, 32'd0);
    check("rst_r_req_ready", {31'd0, r_req_ready}, 32'd0);
    check("rst_r_resp_valid", {31'd0, r_resp_valid}, 32'd0);
    check("rst_r_resp_data", 32'(r_resp_data), 32'd0);
    check("rst_sram_en", {31'd0, sram_en}, 32'd0);
    cyc();
    reset_n = 1'b1;
`ifdef SRAM_CTRL_INIT_EN
    sweep_bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      if (!(sram_en && sram_wmode && sram_addr == AW'(i) && sram_wdata == '0 && sram_wmask == '1
            && !init_done && !w_ready && !r_req_ready)) sweep_bad++;
      cyc();
    end
    check("init_sweep_errors", sweep_bad, 32'd0);
    check("init_done_at_depth", {31'd0, init_done}, 32'd1);
    read_expect(8'h55, 20'h00000, "init_read55");
`else
    #1;
    check("run_init_done", {31'd0, init_done}, 32'd1);
    check("run_w_ready", {31'd0, w_ready}, 32'd1);
    cyc();
`endif
    // Basic write then read
    do_write(8'h10, 20'hABCDE, 10'h3FF);
    read_expect(8'h10, 20'hABCDE, "rd10");
    // Masked writes
    do_write(8'h20, 20'hFFFFF, 10'h3FF);
    do_write(8'h20, 20'h0000F, 10'h001);
    read_expect(8'h20, 20'hFFFFF, "mask1");
    do_write(8'h20, 20'h00000, 10'h003);
    read_expect(8'h20, 20'hFFFF0, "mask3");
    // Same-address write and read in one cycle
    do_write(8'h30, 20'h11111, 10'h3FF);
    r_resp_ready = 1'b1;
    w_valid = 1'b1; w_addr = 8'h30; w_data = 20'h22222; w_mask = 10'h3FF;
    r_req_valid = 1'b1; r_addr = 8'h30;
    #1;
    check("same_w_ready", {31'd0, w_ready}, 32'd1);
    check("same_r_blocked", {31'd0, r_req_ready}, 32'd0);
    cyc();
    w_valid = 1'b0;
    #1;
    check("same_r_ready", {31'd0, r_req_ready}, 32'd1);
    cyc();
    r_req_valid = 1'b0;
    cyc();
    check("same_resp_valid", {31'd0, r_resp_valid}, 32'd1);
    check("same_resp_data", 32'(r_resp_data), 32'h22222);
    drain();
    // Define contents for the randomized regions
    for (int i = 0; i < 16; i++) do_write(AW'(8'h80 + i), DW'($urandom), 10'h3FF);
    for (int i = 0; i < 8; i++) do_write(AW'(8'h40 + i), DW'($urandom), 10'h3FF);
    // Continuous contention: every 4th cycle the read is forced
    r_resp_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      w_valid = 1'b1; w_addr = AW'(8'h80 + $urandom_range(0, 15));
      w_data = DW'($urandom); w_mask = MW'($urandom);
      r_req_valid = 1'b1; r_addr = AW'(8'h80 + $urandom_range(0, 15));
      #1;
      check($sformatf("forced_w_ready_%0d", k), {31'd0, w_ready}, {31'd0, (k % 4) != 3});
      check($sformatf("forced_r_ready_%0d", k), {31'd0, r_req_ready}, {31'd0, (k % 4) == 3});
      cyc();
    end
    w_valid = 1'b0; r_req_valid = 1'b0;
    drain();
    // Backpressure: only two reads outstanding
    r_resp_ready = 1'b0;
    acc = 0;
    r_req_valid = 1'b1; r_addr = 8'h40;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (r_req_ready) acc++;
      cyc();
      r_addr = AW'(8'h40 + acc);
    end
    #1;
    check("bp_accepted", acc, 32'd2);
    check("bp_r_req_ready", {31'd0, r_req_ready}, 32'd0);
    check("bp_resp_valid", {31'd0, r_resp_valid}, 32'd1);
    check("bp_head_data", 32'(r_resp_data), 32'(ref_mem[8'h40]));
    r_resp_ready = 1'b1;
    #1;
    check("bp_third_ready", {31'd0, r_req_ready}, 32'd1);
    cyc();
    r_req_valid = 1'b0;
    drain();
    // Randomized traffic on a small address window
    for (int k = 0; k < 400; k++) begin
      w_valid = 1'($urandom); w_addr = AW'(8'h40 + $urandom_range(0, 7));
      w_data = DW'($urandom); w_mask = MW'($urandom);
      r_req_valid = 1'($urandom); r_addr = AW'(8'h40 + $urandom_range(0, 7));
      r_resp_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    w_valid = 1'b0; r_req_valid = 1'b0;
    drain();
    // Reset while a read is in flight
    do_read(8'h10);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_resp_valid", {31'd0, r_resp_valid}, 32'd0);
    check("midrst_sram_en", {31'd0, sram_en}, 32'd0);
    check("midrst_w_ready", {31'd0, w_ready}, 32'd0);
    cyc();
    reset_n = 1'b1;
`ifdef SRAM_CTRL_INIT_EN
    #1;
    check("resweep_addr", 32'(sram_addr), 32'd0);
    check("resweep_en", {31'd0, sram_en}, 32'd1);
    check("resweep_init_done", {31'd0, init_done}, 32'd0);
    for (int k = 0; k < 300 && !init_done; k++) cyc();
    check("resweep_done", {31'd0, init_done}, 32'd1);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    read_expect(8'h10, 20'h00000, "post_rst_rd10");
`else
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("midrst_discard_%0d", k), {31'd0, r_resp_valid}, 32'd0);
      cyc();
    end
    read_expect(8'h10, 20'hABCDE, "post_rst_rd10");
`endif
    drain();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
